// File: rtl/seg_scan_pkg.sv
// Shared types and the hex to seven-segment table for the scan controller.
// Segment order is {g,f,e,d,c,b,a}, active-low.
package seg_scan_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  // Entry n occupies bits [7n+6:7n]; digits 0..9 then A, b, C, d, E, F.
  localparam logic [16*7-1:0] HEX_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic seg_t hex_to_seg(input logic [3:0] nibble);
    return HEX_TABLE[{3'b000, nibble} * 7 +: 7];
  endfunction

endpackage

// File: rtl/hex7seg_lut.sv
// Combinational nibble to seven-segment decoder.
module hex7seg_lut
  import seg_scan_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed seven-segment scan controller with a double-buffered load
// handshake, per-digit blanking, leading-zero suppression and dead time.
module seg_scan_mux
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int REFRESH_COUNT = 48000,
  parameter int GUARD         = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic                    lz_suppress,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done
);

  localparam int SW = (REFRESH_COUNT > 1) ? $clog2(REFRESH_COUNT) : 1;
  localparam int DW = $clog2(NUM_DIGITS);
  localparam logic [NUM_DIGITS-1:0] DIGIT_ONE = NUM_DIGITS'(1);

  logic [SW-1:0]           slot_cnt;
  logic [DW-1:0]           digit_idx;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic [4*NUM_DIGITS-1:0] active;
  logic                    pending;

  logic                    slot_last;
  logic                    digit_last;
  logic                    frame_end;
  logic                    accept;
  logic                    in_guard;
  logic                    dark;
  logic                    run_zero;
  logic [NUM_DIGITS-1:0]   suppress;
  logic [3:0]              cur_nib;
  seg_t                    cur_seg;

  assign load_ready = ~pending;
  assign accept     = load_valid & load_ready;
  assign slot_last  = (slot_cnt == SW'(REFRESH_COUNT - 1));
  assign digit_last = (digit_idx == DW'(NUM_DIGITS - 1));
  assign frame_end  = slot_last & digit_last;
  assign in_guard   = (int'(slot_cnt) < GUARD);

  // A digit is suppressed while it and every digit to its left are zero;
  // digit 0 always stays lit so a zero value still shows "0".
  always_comb begin
    suppress = '0;
    run_zero = lz_suppress;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      run_zero    = run_zero & (active[4*i +: 4] == 4'h0);
      suppress[i] = run_zero;
    end
  end

  assign cur_nib = active[{digit_idx, 2'b00} +: 4];
  assign dark    = suppress[digit_idx] | blank_mask[digit_idx];

  hex7seg_lut u_lut (
    .nibble (cur_nib),
    .seg    (cur_seg)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_cnt   <= '0;
      digit_idx  <= '0;
      shadow     <= '0;
      active     <= '0;
      pending    <= 1'b0;
      seg        <= SEG_BLANK;
      digit_en   <= '1;
      frame_done <= 1'b0;
    end else begin
      if (slot_last) begin
        slot_cnt  <= '0;
        digit_idx <= digit_last ? '0 : digit_idx + 1'b1;
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end

      // A pending shadow is only promoted at the frame boundary, so the
      // visible value never changes mid-frame.
      if (frame_end && pending) begin
        active  <= shadow;
        pending <= 1'b0;
      end else if (accept) begin
        shadow  <= load_data;
        pending <= 1'b1;
      end

      frame_done <= frame_end;
      seg        <= dark ? SEG_BLANK : cur_seg;
      digit_en   <= (dark || in_guard) ? '1 : ~(DIGIT_ONE << digit_idx);
    end
  end

endmodule
